// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb_pkg
// Description : Shared types and defaults for the register-file writeback
//               arbiter: source index enum, grant vector and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

  localparam int unsigned NUM_SRC          = 3;
  localparam int unsigned DEF_LINK_REG     = 31;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  // Source index; the numeric order is also the round-robin visiting order
  typedef enum logic [1:0] {
    SRC_LD  = 2'd0,
    SRC_JAL = 2'd1,
    SRC_ALU = 2'd2
  } src_e;

  // One bit per source, indexed by src_e
  typedef logic [NUM_SRC-1:0] grant_t;

  function automatic grant_t src_onehot(input src_e src);
    return grant_t'(1) << src;
  endfunction

  // Source that follows src in the load -> JAL -> ALU rotation
  function automatic src_e src_next(input src_e src);
    case (src)
      SRC_LD:  return SRC_JAL;
      SRC_JAL: return SRC_ALU;
      default: return SRC_LD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_slot.sv
`default_nettype none
// ============================================================================
// Module      : wb_slot
// Description : One-entry writeback holding slot with valid/ready handshake.
//               The slot may be drained (granted) and refilled in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_slot #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              drain_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              accept;

  // Ready while empty, or while the current content leaves this cycle
  assign in_ready_o = !valid_q || drain_i;
  assign accept     = in_valid_i && in_ready_o;

  // Next-state: capture wins over drain so drain+refill keeps the slot full
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (accept) begin
      valid_d = 1'b1;
      addr_d  = in_addr_i;
      data_d  = in_data_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  // Slot state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the single register-file write port among ALU, load
//               and JAL-link writeback sources. Each source owns a one-entry
//               slot; one slot is granted per cycle. Exports a pending-write
//               mask built from registered slot state only.
//               Build option WB_ARB_RR_EN: round-robin load -> JAL -> ALU.
//               Without it: fixed load > JAL > ALU with ALU starvation
//               promotion after STARVE_LIMIT waiting cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned LINK_REG     = DEF_LINK_REG,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   alu_valid_i,
  output logic                   alu_ready_o,
  input  logic                   alu_reg_dst_i,
  input  logic [ADDR_W-1:0]      alu_rd_i,
  input  logic [ADDR_W-1:0]      alu_rt_i,
  input  logic [DATA_W-1:0]      alu_data_i,
  input  logic                   ld_valid_i,
  output logic                   ld_ready_o,
  input  logic [ADDR_W-1:0]      ld_rt_i,
  input  logic [DATA_W-1:0]      ld_data_i,
  input  logic                   jal_valid_i,
  output logic                   jal_ready_o,
  input  logic [DATA_W-1:0]      jal_link_i,
  output logic                   rf_we_o,
  output logic [ADDR_W-1:0]      rf_waddr_o,
  output logic [DATA_W-1:0]      rf_wdata_o,
  output logic [(2**ADDR_W)-1:0] pend_mask_o
);

  logic [NUM_SRC-1:0]             in_valid;
  logic [NUM_SRC-1:0]             in_ready;
  logic [NUM_SRC-1:0][ADDR_W-1:0] in_addr;
  logic [NUM_SRC-1:0][DATA_W-1:0] in_data;
  logic [NUM_SRC-1:0]             slot_valid;
  logic [NUM_SRC-1:0][ADDR_W-1:0] slot_addr;
  logic [NUM_SRC-1:0][DATA_W-1:0] slot_data;

  grant_t grant;
  logic   gnt_any;
  src_e   gnt_src;

  // Destination register is resolved once, at capture time
  assign in_valid[SRC_LD]  = ld_valid_i;
  assign in_addr[SRC_LD]   = ld_rt_i;
  assign in_data[SRC_LD]   = ld_data_i;

  assign in_valid[SRC_JAL] = jal_valid_i;
  assign in_addr[SRC_JAL]  = ADDR_W'(LINK_REG);
  assign in_data[SRC_JAL]  = jal_link_i;

  assign in_valid[SRC_ALU] = alu_valid_i;
  assign in_addr[SRC_ALU]  = alu_reg_dst_i ? alu_rd_i : alu_rt_i;
  assign in_data[SRC_ALU]  = alu_data_i;

  assign ld_ready_o  = in_ready[SRC_LD];
  assign jal_ready_o = in_ready[SRC_JAL];
  assign alu_ready_o = in_ready[SRC_ALU];

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_slot
    wb_slot #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_slot (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .in_valid_i (in_valid[s]),
      .in_ready_o (in_ready[s]),
      .in_addr_i  (in_addr[s]),
      .in_data_i  (in_data[s]),
      .drain_i    (grant[s]),
      .valid_o    (slot_valid[s]),
      .addr_o     (slot_addr[s]),
      .data_o     (slot_data[s])
    );
  end

`ifdef WB_ARB_RR_EN
  src_e       rr_ptr_q, rr_ptr_d;
  logic [2:0] rr_idx;

  // Round-robin pick: first valid slot at or after the pointer, wrapping
  always_comb begin
    gnt_any = 1'b0;
    gnt_src = SRC_LD;
    rr_idx  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      rr_idx = {1'b0, rr_ptr_q} + 3'(k);
      if (rr_idx >= 3'd3) begin
        rr_idx = rr_idx - 3'd3;
      end
      if (!gnt_any && slot_valid[rr_idx[1:0]]) begin
        gnt_any = 1'b1;
        gnt_src = src_e'(rr_idx[1:0]);
      end
    end
  end

  // Pointer moves to the source after the one just granted
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      rr_ptr_d = src_next(gnt_src);
    end
  end

  // Round-robin pointer register; reset makes load the first candidate
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= SRC_LD;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  localparam int unsigned       WAIT_W   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] alu_wait_q, alu_wait_d;
  logic              alu_promote;

  assign alu_promote = (alu_wait_q == WAIT_MAX);

  // Fixed priority load > JAL > ALU, with a starved ALU jumping the queue
  always_comb begin
    gnt_any = 1'b1;
    gnt_src = SRC_LD;
    if (alu_promote && slot_valid[SRC_ALU]) begin
      gnt_src = SRC_ALU;
    end else if (slot_valid[SRC_LD]) begin
      gnt_src = SRC_LD;
    end else if (slot_valid[SRC_JAL]) begin
      gnt_src = SRC_JAL;
    end else if (slot_valid[SRC_ALU]) begin
      gnt_src = SRC_ALU;
    end else begin
      gnt_any = 1'b0;
    end
  end

  // Count cycles the ALU slot is held back; saturate, clear on its grant
  always_comb begin
    alu_wait_d = alu_wait_q;
    if (grant[SRC_ALU]) begin
      alu_wait_d = '0;
    end else if (slot_valid[SRC_ALU] && !alu_promote) begin
      alu_wait_d = alu_wait_q + WAIT_W'(1);
    end
  end

  // ALU wait counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alu_wait_q <= '0;
    end else begin
      alu_wait_q <= alu_wait_d;
    end
  end
`endif

  assign grant = gnt_any ? src_onehot(gnt_src) : grant_t'(0);

  // Write-port mux from the granted slot; zero when nothing is granted
  always_comb begin
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (grant[s]) begin
        rf_waddr_o = slot_addr[s];
        rf_wdata_o = slot_data[s];
      end
    end
  end

  // Register 0 writes are consumed but never reach the register file
  assign rf_we_o = gnt_any && (rf_waddr_o != '0);

  // Pending-write mask from registered slot state; register 0 never flagged
  always_comb begin
    pend_mask_o = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (slot_valid[s] && (slot_addr[s] != '0)) begin
        pend_mask_o[slot_addr[s]] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Self-checking bench for regfile_wb_arbiter. Expected writes
//               are queued when a handshake is seen and compared against the
//               register-file write port as writes appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int DW     = 32;
  localparam int AW     = 5;
  localparam int LINK   = 31;
  localparam int STARVE = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alu_valid, alu_ready, alu_reg_dst;
  logic [AW-1:0] alu_rd, alu_rt;
  logic [DW-1:0] alu_data;
  logic          ld_valid, ld_ready;
  logic [AW-1:0] ld_rt;
  logic [DW-1:0] ld_data;
  logic          jal_valid, jal_ready;
  logic [DW-1:0] jal_link;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [31:0]   pend_mask;

  regfile_wb_arbiter dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .alu_valid_i   (alu_valid),
    .alu_ready_o   (alu_ready),
    .alu_reg_dst_i (alu_reg_dst),
    .alu_rd_i      (alu_rd),
    .alu_rt_i      (alu_rt),
    .alu_data_i    (alu_data),
    .ld_valid_i    (ld_valid),
    .ld_ready_o    (ld_ready),
    .ld_rt_i       (ld_rt),
    .ld_data_i     (ld_data),
    .jal_valid_i   (jal_valid),
    .jal_ready_o   (jal_ready),
    .jal_link_i    (jal_link),
    .rf_we_o       (rf_we),
    .rf_waddr_o    (rf_waddr),
    .rf_wdata_o    (rf_wdata),
    .pend_mask_o   (pend_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_fail   = 0;
  int  li;
  bit  acc;
  int  exp_a;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (a != '0) exp_q.push_back('{a: a, d: d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; ld_valid = 1'b0; jal_valid = 1'b0;
  endtask

  // Queue what the handshakes of the current cycle will capture (ld, jal, alu)
  task automatic note_accepts();
    if (ld_valid && ld_ready)   push_exp(ld_rt, ld_data);
    if (jal_valid && jal_ready) push_exp(AW'(LINK), jal_link);
    if (alu_valid && alu_ready) push_exp(alu_reg_dst ? alu_rd : alu_rt, alu_data);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_we"}, 64'(rf_we), 64'd0);
    check_eq({tag, "_pend"}, 64'(pend_mask), 64'd0);
    check_eq({tag, "_rdy"}, 64'({ld_ready, jal_ready, alu_ready}), 64'b111);
  endtask

  // Scoreboard: every register-file write must match the next queued entry
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_we", 64'(rf_we), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("sb_waddr", 64'(rf_waddr), 64'(mon_e.a));
        check_eq("sb_wdata", 64'(rf_wdata), 64'(mon_e.d));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    alu_reg_dst = 1'b0; alu_rd = '0; alu_rt = '0; alu_data = '0;
    ld_rt = '0; ld_data = '0; jal_link = '0;

    // Reset state
    #12;
    check_eq("rst_we",    64'(rf_we), 64'd0);
    check_eq("rst_waddr", 64'(rf_waddr), 64'd0);
    check_eq("rst_wdata", 64'(rf_wdata), 64'd0);
    check_eq("rst_pend",  64'(pend_mask), 64'd0);
    check_eq("rst_ready", 64'({ld_ready, jal_ready, alu_ready}), 64'b111);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single ALU write via rd; inputs scrambled after acceptance
    alu_valid = 1'b1; alu_reg_dst = 1'b1; alu_rd = 5'd8; alu_rt = 5'd3; alu_data = 32'h1234;
    note_accepts();
    tick();
    idle_inputs(); alu_data = 32'hFFFF_FFFF; alu_rd = 5'd1;
    check_eq("alu_we",    64'(rf_we), 64'd1);
    check_eq("alu_waddr", 64'(rf_waddr), 64'd8);
    check_eq("alu_wdata", 64'(rf_wdata), 64'h1234);
    check_eq("alu_pend",  64'(pend_mask), 64'h100);
    tick();
    check_quiet("alu_after");

    // ALU write via rt
    alu_valid = 1'b1; alu_reg_dst = 1'b0; alu_rd = 5'd4; alu_rt = 5'd12; alu_data = 32'h77;
    note_accepts();
    tick();
    idle_inputs();
    check_eq("alu_rt_sel", 64'(rf_waddr), 64'd12);
    tick();

    // All three sources in the same cycle
    ld_valid = 1'b1; ld_rt = 5'd9; ld_data = 32'hAA;
    jal_valid = 1'b1; jal_link = 32'h400;
    alu_valid = 1'b1; alu_reg_dst = 1'b1; alu_rd = 5'd10; alu_data = 32'h55;
    note_accepts();
    tick();
    idle_inputs();
    check_eq("all3_pend",  64'(pend_mask), 64'h8000_0600);
    check_eq("all3_w0",    64'(rf_waddr), 64'd9);
    check_eq("all3_rdy0",  64'({ld_ready, jal_ready, alu_ready}), 64'b100);
    tick();
    check_eq("all3_w1",    64'(rf_waddr), 64'd31);
    check_eq("all3_d1",    64'(rf_wdata), 64'h400);
    tick();
    check_eq("all3_w2",    64'(rf_waddr), 64'd10);
    tick();
    check_quiet("all3_done");

    // ALU write to register 0: consumed, never written
    alu_valid = 1'b1; alu_reg_dst = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    note_accepts();
    tick();
    idle_inputs();
    check_eq("r0_we",   64'(rf_we), 64'd0);
    check_eq("r0_pend", 64'(pend_mask), 64'd0);
    check_eq("r0_rdy",  64'(alu_ready), 64'd1);
    tick();
    check_quiet("r0_after");

`ifndef WB_ARB_RR_EN
    // Starvation: continuous loads with one ALU write pending
    li = 0;
    alu_valid = 1'b1; alu_reg_dst = 1'b1; alu_rd = 5'd20; alu_data = 32'hA1;
    ld_valid = 1'b1; ld_rt = AW'(1 + li); ld_data = 32'h1000 + 32'(li);
    for (int cyc = 0; cyc < 9; cyc++) begin
      acc = 1'b0;
      if (ld_ready) begin
        push_exp(ld_rt, ld_data);
        li++;
        acc = 1'b1;
        if (li == STARVE) push_exp(5'd20, 32'hA1);
      end
      tick();
      alu_valid = 1'b0; alu_data = '0;
      if (acc) begin
        ld_rt = AW'(1 + li); ld_data = 32'h1000 + 32'(li);
      end
      check_eq("starve_we", 64'(rf_we), 64'd1);
      if (cyc == STARVE) begin
        check_eq("starve_alu_gnt", 64'(rf_waddr), 64'd20);
        check_eq("starve_ld_hold", 64'(ld_ready), 64'd0);
      end
    end
    idle_inputs();
    tick();
    tick();
    check_quiet("starve_done");
`else
    // Round-robin: all sources held valid, grants rotate with no gaps
    ld_valid = 1'b1; ld_rt = 5'd5; ld_data = 32'h2000;
    jal_valid = 1'b1; jal_link = 32'h3000;
    alu_valid = 1'b1; alu_reg_dst = 1'b1; alu_rd = 5'd6; alu_data = 32'h4000;
    for (int cyc = 0; cyc < 9; cyc++) begin
      note_accepts();
      if (ld_ready)  ld_data  = ld_data + 32'd1;
      if (jal_ready) jal_link = jal_link + 32'd1;
      if (alu_ready) alu_data = alu_data + 32'd1;
      tick();
      case (cyc % 3)
        0:       exp_a = 5;
        1:       exp_a = 31;
        default: exp_a = 6;
      endcase
      check_eq("rr_no_gap", 64'(rf_we), 64'd1);
      check_eq("rr_order",  64'(rf_waddr), 64'(exp_a));
    end
    idle_inputs();
    tick();
    tick();
    tick();
    check_quiet("rr_done");
`endif

    // Reset while all three slots are full: everything discarded
    ld_valid = 1'b1; ld_rt = 5'd13; ld_data = 32'hE1;
    jal_valid = 1'b1; jal_link = 32'hE2;
    alu_valid = 1'b1; alu_reg_dst = 1'b1; alu_rd = 5'd14; alu_data = 32'hE3;
    tick();
    idle_inputs();
    check_eq("full_pend", 64'(pend_mask), 64'h8000_6000);
    #1;
    rst_n = 1'b0;
    #1;
    check_quiet("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet("postrst");
    end

    // First grants after reset follow the reset priority order
    ld_valid = 1'b1; ld_rt = 5'd2; ld_data = 32'hB0;
    jal_valid = 1'b1; jal_link = 32'h800;
    alu_valid = 1'b1; alu_reg_dst = 1'b1; alu_rd = 5'd3; alu_data = 32'hC0;
    note_accepts();
    tick();
    idle_inputs();
    check_eq("postrst_first", 64'(rf_waddr), 64'd2);
    tick();
    tick();
    tick();
    tick();
    check_quiet("final");
    check_eq("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
